// File: rtl/uart_rx_deser.sv
// UART receive deserializer: RX synchronizer, start-bit qualification, 8N1 framing, byte strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (8E1).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rxs
// S_START | half-bit wait, re-check start bit to reject glitches
// S_DATA  | sampling 8 data bits at mid-bit, LSB first
// S_PARITY| sampling the parity bit (UART_RX_PARITY_EN only)
// S_STOP  | sampling the stop bit, deciding deliver/drop/error
// S_BREAK | stop bit was low; wait for line to return high
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_rx_notfull,
  output logic [7:0] o_data,
  output logic       o_irq,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE     = BAUD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   irq_q, irq_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  logic rxs;
  logic baud_zero;
  logic par_bad;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign baud_zero = (baud_q == '0);

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus the parity bit must XOR to zero.
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_rx};
    baud_d  = baud_zero ? baud_q : (baud_q - BAUD_ONE);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    irq_d   = 1'b0;
    ovr_d   = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
    busy_d  = (state_q == S_START) || (state_q == S_DATA) ||
              (state_q == S_PARITY) || (state_q == S_STOP);
`else
    busy_d  = (state_q == S_START) || (state_q == S_DATA) ||
              (state_q == S_STOP);
`endif

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          baud_d  = BAUD_HALF_M1;
        end
      end

      S_START: begin
        if (baud_zero) begin
          if (!rxs) begin
            state_d = S_DATA;
            baud_d  = BAUD_FULL_M1;
            bit_d   = 3'd0;
            ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (baud_zero) begin
          // Shift in at the MSB so the first bit lands in bit 0 after eight samples.
          shift_d = {rxs, shift_q[7:1]};
          baud_d  = BAUD_FULL_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_zero) begin
          par_d   = rxs;
          baud_d  = BAUD_FULL_M1;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (baud_zero) begin
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad;
`endif
          if (rxs) begin
            state_d = S_IDLE;
            if (!par_bad) begin
              if (i_rx_notfull) begin
                data_d = shift_q;
                irq_d  = 1'b1;
              end else begin
                ovr_d  = 1'b1;
              end
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // Held-low line must return high before a new start bit is accepted.
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_irq       = irq_q;
  assign o_busy      = busy_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: directed frames plus randomized frames against a frame-level outcome model.
// Honours UART_RX_PARITY_EN to send a parity bit and run the parity cases.
module tb_uart_rx_deser;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_rx_notfull = 1'b1;
  logic [7:0] o_data;
  logic       o_irq, o_busy, o_frame_err, o_overrun, o_parity_err;

  int checks = 0;
  int errors = 0;

  int         irq_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] irq_log[$];
  bit         win = 1'b0;
  int         low_run = 0;
  int         max_low = 0;
  int         high_cnt = 0;
  bit         par_flip = 1'b0;

  uart_rx_deser #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (i_rx),
    .i_rx_notfull (i_rx_notfull),
    .o_data       (o_data),
    .o_irq        (o_irq),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err)
  );

  always #5 clk = ~clk;

  // Pulse counting and busy-window statistics, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_irq === 1'b1) begin
      irq_cnt++;
      irq_log.push_back(o_data);
    end
    if (o_overrun === 1'b1) ovr_cnt++;
    if (!win) begin
      low_run  = 0;
      max_low  = 0;
      high_cnt = 0;
    end else if (o_busy === 1'b1) begin
      high_cnt++;
      low_run = 0;
    end else begin
      low_run++;
      if (low_run > max_low) max_low = low_run;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    wait_clks(CPB);
  endtask

  // Start, 8 data LSB first, optional even parity (inverted when par_flip), stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_ON) send_bit((^d) ^ par_flip);
    send_bit(stop_v);
    if (stop_v) i_rx = 1'b1;
  endtask

  initial begin
    int         irq0, ovr0, hc, ml;
    logic [7:0] exp_data;
    logic [7:0] d;
    bit         stop_v, nf, good;

    wait_clks(3);
    chk("rst_data", 32'(o_data), 32'h00);
    chk("rst_irq", 32'(o_irq), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_ferr", 32'(o_frame_err), 32'h0);
    chk("rst_ovr", 32'(o_overrun), 32'h0);
    chk("rst_perr", 32'(o_parity_err), 32'h0);
    rst_n = 1'b1;
    wait_clks(CPB);

    i_rx_notfull = 1'b1;
    irq0 = irq_cnt; ovr0 = ovr_cnt;
    send_frame(8'hA5, 1'b1);
    wait_clks(CPB);
    chk("a5_irq", 32'(irq_cnt - irq0), 32'd1);
    chk("a5_data", 32'(o_data), 32'hA5);
    chk("a5_busy", 32'(o_busy), 32'h0);
    chk("a5_ferr", 32'(o_frame_err), 32'h0);
    chk("a5_ovr", 32'(ovr_cnt - ovr0), 32'd0);

    irq_log.delete();
    win = 1'b1;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    ml = max_low;
    win = 1'b0;
    wait_clks(CPB);
    chk("b2b_count", 32'(irq_log.size()), 32'd2);
    chk("b2b_first", 32'(irq_log[0]), 32'h3C);
    chk("b2b_second", 32'(irq_log[1]), 32'hC3);
    chk("b2b_busy_gap", 32'(ml <= CPB / 2 + 4), 32'd1);

    irq0 = irq_cnt;
    win = 1'b1;
    i_rx = 1'b0;
    wait_clks(4);
    i_rx = 1'b1;
    wait_clks(3 * CPB);
    hc = high_cnt;
    win = 1'b0;
    chk("glitch_irq", 32'(irq_cnt - irq0), 32'd0);
    chk("glitch_busy_seen", 32'(hc >= 1), 32'd1);
    chk("glitch_busy_max", 32'(hc <= 8), 32'd1);
    chk("glitch_busy_end", 32'(o_busy), 32'h0);
    chk("glitch_data", 32'(o_data), 32'hC3);

    irq0 = irq_cnt; ovr0 = ovr_cnt;
    send_frame(8'h55, 1'b0);
    win = 1'b1;
    wait_clks(40 * CPB);
    hc = high_cnt;
    win = 1'b0;
    chk("brk_ferr", 32'(o_frame_err), 32'h1);
    chk("brk_irq", 32'(irq_cnt - irq0), 32'd0);
    chk("brk_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    chk("brk_no_retrigger", 32'(hc), 32'd0);
    chk("brk_data", 32'(o_data), 32'hC3);
    i_rx = 1'b1;
    wait_clks(CPB);
    chk("brk_ferr_held", 32'(o_frame_err), 32'h1);
    irq0 = irq_cnt;
    send_frame(8'h11, 1'b1);
    wait_clks(4);
    chk("recov_ferr", 32'(o_frame_err), 32'h0);
    chk("recov_irq", 32'(irq_cnt - irq0), 32'd1);
    chk("recov_data", 32'(o_data), 32'h11);

    i_rx_notfull = 1'b0;
    irq0 = irq_cnt; ovr0 = ovr_cnt;
    send_frame(8'h7E, 1'b1);
    wait_clks(4);
    chk("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
    chk("ovr_irq", 32'(irq_cnt - irq0), 32'd0);
    chk("ovr_data", 32'(o_data), 32'h11);
    i_rx_notfull = 1'b1;
    exp_data = 8'h11;

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    irq0 = irq_cnt;
    send_frame(8'h01, 1'b1);
    wait_clks(4);
    chk("par_ok_irq", 32'(irq_cnt - irq0), 32'd1);
    chk("par_ok_data", 32'(o_data), 32'h01);
    chk("par_ok_perr", 32'(o_parity_err), 32'h0);
    par_flip = 1'b1;
    irq0 = irq_cnt; ovr0 = ovr_cnt;
    send_frame(8'h01, 1'b1);
    wait_clks(4);
    chk("par_bad_perr", 32'(o_parity_err), 32'h1);
    chk("par_bad_irq", 32'(irq_cnt - irq0), 32'd0);
    chk("par_bad_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    par_flip = 1'b0;
    exp_data = 8'h01;
`endif

    // Random frames: outcome derived from stop bit, parity validity and FIFO space.
    for (int k = 0; k < 24; k++) begin
      d        = 8'($urandom);
      stop_v   = ($urandom_range(0, 3) != 0);
      nf       = ($urandom_range(0, 3) != 0);
      par_flip = PAR_ON && ($urandom_range(0, 3) == 0);
      i_rx_notfull = nf;
      irq0 = irq_cnt; ovr0 = ovr_cnt;
      send_frame(d, stop_v);
      if (!stop_v) begin
        i_rx = 1'b1;
        wait_clks(2 * CPB);
      end else begin
        wait_clks(2 + $urandom_range(0, 20));
      end
      good = stop_v && !par_flip;
      if (good && nf) exp_data = d;
      chk($sformatf("rnd%0d_irq", k), 32'(irq_cnt - irq0), 32'(good && nf));
      chk($sformatf("rnd%0d_ovr", k), 32'(ovr_cnt - ovr0), 32'(good && !nf));
      chk($sformatf("rnd%0d_data", k), 32'(o_data), 32'(exp_data));
      chk($sformatf("rnd%0d_ferr", k), 32'(o_frame_err), 32'(!stop_v));
      chk($sformatf("rnd%0d_perr", k), 32'(o_parity_err), 32'(par_flip));
    end
    par_flip = 1'b0;

    i_rx_notfull = 1'b1;
    irq0 = irq_cnt;
    i_rx = 1'b0;
    wait_clks(4 * CPB);
    chk("mid_busy", 32'(o_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(o_data), 32'h00);
    chk("mid_rst_irq", 32'(o_irq), 32'h0);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    chk("mid_rst_ferr", 32'(o_frame_err), 32'h0);
    chk("mid_rst_ovr", 32'(o_overrun), 32'h0);
    chk("mid_rst_perr", 32'(o_parity_err), 32'h0);
    i_rx = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(12 * CPB);
    chk("mid_no_emit", 32'(irq_cnt - irq0), 32'd0);
    chk("mid_data_after", 32'(o_data), 32'h00);
    chk("mid_busy_after", 32'(o_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
